fetch_unit: RTL and testbench

Instruction-fetch stage of the MIPS datapath. It owns the program counter, requests instructions from instruction memory through a valid handshake, and presents each instruction, including its opcode field, to the main decoder for one issue window. It consumes Jump/Branch from the decoder and Zero from the ALU to select the next PC.

---
 rtl/mips_pkg.sv | 18 +
 rtl/next_pc_calc.sv | 34 +++
 rtl/fetch_unit.sv | 138 +++++++++++++
 tb/tb_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, fetch FSM state encoding and default reset PC.
package mips_pkg;

   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_J   = 6'b000010;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFetch = 2'd1,
      StIssue = 2'd2,
      StHalt  = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump, then taken branch, then sequential.
module next_pc_calc #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] pc_plus4,
   input  logic [31:0]       inst,
   input  logic              Jump,
   input  logic              Branch,
   input  logic              Zero,
   output logic [ADDR_W-1:0] next_pc
);

   logic [ADDR_W-1:0] jump_tgt;
   logic [ADDR_W-1:0] branch_tgt;
   logic [ADDR_W-1:0] sel_pc;
   logic              unused_opcode;

   assign jump_tgt   = {pc_plus4[ADDR_W-1:28], inst[25:0], 2'b00};
   // Sign-extended word offset; the add wraps naturally at ADDR_W bits.
   assign branch_tgt = pc_plus4 + {{(ADDR_W-18){inst[15]}}, inst[15:0], 2'b00};

   always_comb begin
      sel_pc = pc_plus4;
      if (Jump) begin
         sel_pc = jump_tgt;
      end else if (Branch && Zero) begin
         sel_pc = branch_tgt;
      end
   end

   assign next_pc       = {sel_pc[ADDR_W-1:2], 2'b00};
   assign unused_opcode = ^inst[31:26];

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, handshakes with imem, issues one instruction at a time.
// Optional watchdog halts the stage when FETCH_TIMEOUT_EN is defined.
module fetch_unit
   import mips_pkg::*;
#(
   parameter int unsigned       ADDR_W         = 32,
   parameter logic [ADDR_W-1:0] RESET_PC       = ADDR_W'(DEFAULT_RESET_PC),
   parameter int unsigned       TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   input  logic              imem_valid,
   input  logic              stall,
   input  logic              Jump,
   input  logic              Branch,
   input  logic              Zero,
   output logic [31:0]       inst_out,
   output logic [5:0]        opcode,
   output logic [ADDR_W-1:0] pc_out,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic              inst_valid,
   output logic              fetch_err
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       inst_q, inst_d;
   logic [ADDR_W-1:0] next_pc;
   logic              timeout_hit;

   next_pc_calc #(
      .ADDR_W (ADDR_W)
   ) u_next_pc_calc (
      .pc_plus4 (pc_plus4),
      .inst     (inst_q),
      .Jump     (Jump),
      .Branch   (Branch),
      .Zero     (Zero),
      .next_pc  (next_pc)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      case (state_q)
         StIdle: begin
            state_d = StFetch;
         end
         StFetch: begin
            if (imem_valid) begin
               inst_d  = imem_rdata;
               state_d = StIssue;
            end else if (timeout_hit) begin
               state_d = StHalt;
            end
         end
         StIssue: begin
            if (!stall) begin
               pc_d    = next_pc;
               state_d = StFetch;
            end
         end
         StHalt: begin
            state_d = StHalt;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         pc_q    <= RESET_PC;
         inst_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
      end
   end

`ifdef FETCH_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   // Hit on the last of TIMEOUT_CYCLES consecutive FETCH cycles without a response.
   assign timeout_hit = (state_q == StFetch) && !imem_valid &&
                        (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if ((state_d == StFetch) && (state_q != StFetch)) begin
         cnt_d = '0;
      end else if ((state_q == StFetch) && !imem_valid) begin
         cnt_d = cnt_q + 1'b1;
      end
      if (timeout_hit) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign fetch_err = err_q;
`else
   logic unused_timeout_cfg;

   assign timeout_hit        = 1'b0;
   assign fetch_err          = 1'b0;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

   assign imem_req   = (state_q == StFetch);
   assign imem_addr  = pc_q;
   assign inst_valid = (state_q == StIssue);
   assign inst_out   = inst_q;
   assign opcode     = inst_q[31:26];
   assign pc_out     = pc_q;
   assign pc_plus4   = pc_q + ADDR_W'(4);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized fetch/issue traffic
// checked against a behavioural PC/instruction model.
module tb_fetch_unit;

   localparam int unsigned ADDR_W   = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0400;
   localparam int unsigned TIMEOUT  = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_valid;
   logic        stall;
   logic        Jump;
   logic        Branch;
   logic        Zero;
   logic [31:0] inst_out;
   logic [5:0]  opcode;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;
   logic        inst_valid;
   logic        fetch_err;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] m_pc;
   logic [31:0] m_inst;

   fetch_unit #(
      .ADDR_W         (ADDR_W),
      .RESET_PC       (RESET_PC),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .imem_valid (imem_valid),
      .stall      (stall),
      .Jump       (Jump),
      .Branch     (Branch),
      .Zero       (Zero),
      .inst_out   (inst_out),
      .opcode     (opcode),
      .pc_out     (pc_out),
      .pc_plus4   (pc_plus4),
      .inst_valid (inst_valid),
      .fetch_err  (fetch_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_req"}, 32'(imem_req), 32'd0);
      check({tag, "_addr"}, imem_addr, RESET_PC);
      check({tag, "_pc"}, pc_out, RESET_PC);
      check({tag, "_inst"}, inst_out, 32'd0);
      check({tag, "_ivalid"}, 32'(inst_valid), 32'd0);
      check({tag, "_err"}, 32'(fetch_err), 32'd0);
   endtask

   // Spec-level next PC: jump region splice, signed word offset, or sequential.
   function automatic logic [31:0] model_next(input logic j, input logic b, input logic z);
      logic [31:0] p4;
      int          off;
      p4 = m_pc + 32'd4;
      if (j) return ((p4 & 32'hF000_0000) | ((m_inst & 32'h03FF_FFFF) << 2)) & ~32'd3;
      if (b && z) begin
         off = $signed(m_inst[15:0]);
         return (p4 + 32'(off * 4)) & ~32'd3;
      end
      return p4;
   endfunction

   task automatic check_issue(input string tag);
      check({tag, "_ivalid"}, 32'(inst_valid), 32'd1);
      check({tag, "_req"}, 32'(imem_req), 32'd0);
      check({tag, "_inst"}, inst_out, m_inst);
      check({tag, "_opcode"}, 32'(opcode), 32'(m_inst[31:26]));
      check({tag, "_pc"}, pc_out, m_pc);
      check({tag, "_pc4"}, pc_plus4, m_pc + 32'd4);
   endtask

   // Entered at a negedge with the DUT in FETCH; leaves at a negedge in ISSUE.
   task automatic do_fetch(input int waits, input logic [31:0] data);
      for (int i = 0; i < waits; i++) begin
         check("wait_req", 32'(imem_req), 32'd1);
         check("wait_addr", imem_addr, m_pc);
         check("wait_ivalid", 32'(inst_valid), 32'd0);
         imem_valid = 1'b0;
         imem_rdata = $urandom;
         @(negedge clk);
      end
      check("fetch_req", 32'(imem_req), 32'd1);
      check("fetch_addr", imem_addr, m_pc);
      imem_valid = 1'b1;
      imem_rdata = data;
      @(negedge clk);
      imem_valid = 1'b0;
      imem_rdata = $urandom;
      m_inst     = data;
      check_issue("issue");
   endtask

   // Entered at a negedge in ISSUE; leaves at a negedge in FETCH at the model's next PC.
   task automatic do_issue(input int stalls, input logic j, input logic b, input logic z);
      logic [31:0] nxt;
      for (int i = 0; i < stalls; i++) begin
         stall  = 1'b1;
         Jump   = 1'(i);
         Branch = 1'($urandom_range(0, 1));
         Zero   = 1'($urandom_range(0, 1));
         @(negedge clk);
         check_issue("stall");
      end
      stall  = 1'b0;
      Jump   = j;
      Branch = b;
      Zero   = z;
      nxt    = model_next(j, b, z);
      @(negedge clk);
      m_pc   = nxt;
      Jump   = 1'b0;
      Branch = 1'b0;
      Zero   = 1'b0;
      check("next_req", 32'(imem_req), 32'd1);
      check("next_addr", imem_addr, m_pc);
      check("next_ivalid", 32'(inst_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] target;
      logic [31:0] off;
      int          steps;

      rst_n      = 1'b0;
      imem_valid = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      stall      = 1'b0;
      Jump       = 1'b0;
      Branch     = 1'b0;
      Zero       = 1'b0;
      m_pc       = RESET_PC;
      m_inst     = 32'd0;
      repeat (2) @(negedge clk);
      check_reset_values("reset");

      // Release with a stray valid still high during IDLE; it must be ignored.
      rst_n = 1'b1;
      @(negedge clk);
      check("first_req", 32'(imem_req), 32'd1);
      check("first_addr", imem_addr, 32'h400);
      check("stray_inst", inst_out, 32'd0);
      check("stray_ivalid", 32'(inst_valid), 32'd0);
      do_fetch(0, 32'h8C01_0004);
      check("lw_opcode", 32'(opcode), 32'b100011);
      do_issue(0, 1'b0, 1'b0, 1'b0);
      check("seq_addr", imem_addr, 32'h404);
      do_fetch(1, 32'h0022_1820);
      do_issue(0, 1'b0, 1'b0, 1'b0);

      do_fetch(0, 32'h1000_FFFF);
      do_issue(0, 1'b0, 1'b1, 1'b1);
      check("br_taken", imem_addr, 32'h408);
      do_fetch(2, 32'h1000_FFFF);
      do_issue(0, 1'b0, 1'b1, 1'b0);
      check("br_not_taken", imem_addr, 32'h40C);

      // Walk up to 0x10000010 with maximal forward branches.
      target = 32'h1000_0010;
      steps  = 0;
      while (m_pc != target && steps < 3000) begin
         off = (target - m_pc - 32'd4) >> 2;
         if (off > 32'h7FFF) off = 32'h7FFF;
         do_fetch(0, 32'h1000_0000 | off);
         do_issue(0, 1'b0, 1'b1, 1'b1);
         steps++;
      end
      check("walk_pc", imem_addr, target);

      do_fetch(0, 32'h0800_0040);
      do_issue(0, 1'b1, 1'b1, 1'($urandom_range(0, 1)));
      check("jump_priority", imem_addr, 32'h1000_0100);

      do_fetch(0, 32'h1000_0010);
      do_issue(3, 1'b0, 1'b1, 1'b1);
      check("stall_release", imem_addr, 32'h1000_0144);

      repeat (40) begin
         do_fetch($urandom_range(0, 3), $urandom);
         do_issue($urandom_range(0, 2), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      do_fetch(5, $urandom);
      do_issue(0, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset in the middle of a pending fetch.
      imem_valid = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_values("mid_reset");
      imem_valid = 1'b1;
      m_pc       = RESET_PC;
      m_inst     = 32'd0;
      @(negedge clk);
      check_reset_values("held_reset");
      rst_n = 1'b1;
      @(negedge clk);
      check("rerun_addr", imem_addr, 32'h400);
      check("rerun_inst", inst_out, 32'd0);

      // Branch backwards past zero, then sequential wrap from 0xFFFFFFFC.
      do_fetch(0, 32'h1000_FEFE);
      do_issue(0, 1'b0, 1'b1, 1'b1);
      check("wrap_branch", imem_addr, 32'hFFFF_FFFC);
      do_fetch(0, 32'h0000_0000);
      check("wrap_pc4", pc_plus4, 32'h0000_0000);
      do_issue(0, 1'b0, 1'b0, 1'b0);
      check("wrap_addr", imem_addr, 32'h0000_0000);

`ifdef FETCH_TIMEOUT_EN
      imem_valid = 1'b0;
      for (int i = 0; i < int'(TIMEOUT); i++) begin
         check("to_req", 32'(imem_req), 32'd1);
         check("to_err", 32'(fetch_err), 32'd0);
         @(negedge clk);
      end
      check("halt_err", 32'(fetch_err), 32'd1);
      check("halt_req", 32'(imem_req), 32'd0);
      check("halt_ivalid", 32'(inst_valid), 32'd0);
      imem_valid = 1'b1;
      repeat (4) @(negedge clk);
      check("halt_sticky_err", 32'(fetch_err), 32'd1);
      check("halt_sticky_req", 32'(imem_req), 32'd0);
      check("halt_sticky_ivalid", 32'(inst_valid), 32'd0);
      rst_n = 1'b0;
      #1 check_reset_values("halt_reset");
      imem_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_halt_req", 32'(imem_req), 32'd1);
`else
      imem_valid = 1'b0;
      repeat (TIMEOUT + 4) @(negedge clk);
      check("no_to_req", 32'(imem_req), 32'd1);
      check("no_to_addr", imem_addr, 32'h0000_0000);
      check("no_to_err", 32'(fetch_err), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

endmodule
